// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: timed or single A/B/I steps with direction, polarity and index.
// Optional per-step period jitter from a 16-bit LFSR when ENCEMU_JITTER_EN is defined.
module encoder_emulator #(
    parameter int K_PERIOD_W = 16,
    parameter int K_POS_W    = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [K_PERIOD_W-1:0] i_period,
    input  logic                  i_reverse,
    input  logic                  i_polarity,
    input  logic [K_POS_W-1:0]    i_steps_per_rev,
    input  logic                  i_single_step,
    output logic                  o_a,
    output logic                  o_b,
    output logic                  o_i,
    output logic                  o_step,
    output logic                  o_dir_change,
    output logic [K_POS_W-1:0]    o_position
);

    localparam logic [K_PERIOD_W:0] TERM_ONE = (K_PERIOD_W+1)'(1);

    logic [K_PERIOD_W-1:0] count_reg, count_next;
    logic [K_PERIOD_W:0]   terminal;
    logic [K_PERIOD_W:0]   jitter;
    logic                  period_zero;
    logic                  timed_fire;
    logic                  single_fire;
    logic                  fire;

    logic                  a_raw_reg, b_raw_reg;
    logic                  a_raw_next, b_raw_next;
    logic [1:0]            phase_cur, phase_next;
    logic                  last_rev_reg;
    logic [K_POS_W-1:0]    position_reg, position_next;
    logic                  index_reg, index_next;
    logic                  step_reg;
    logic                  dir_change_reg;
    logic                  index_enabled;

`ifdef ENCEMU_JITTER_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_reg <= 16'hACE1;
        end else if (fire) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    // Short periods stay exact so the jitter never dominates the step rate.
    assign jitter = (i_period >= K_PERIOD_W'(4)) ? (K_PERIOD_W+1)'(lfsr_reg[1:0]) : '0;
`else
    assign jitter = '0;
`endif

    always_comb begin
        period_zero = (i_period == '0);
        terminal    = {1'b0, i_period} - TERM_ONE + jitter;
        // >= rather than == so a period lowered mid-count fires right away.
        timed_fire  = i_enable && !period_zero && ({1'b0, count_reg} >= terminal);
        single_fire = i_single_step && period_zero && i_enable;
        fire        = timed_fire || single_fire;
    end

    always_comb begin
        count_next = count_reg;
        if (i_enable) begin
            if (period_zero || timed_fire) begin
                count_next = '0;
            end else begin
                count_next = count_reg + K_PERIOD_W'(1);
            end
        end
    end

    // Phase is recovered from the registered raw pair: 0=(0,0) 1=(1,0) 2=(1,1) 3=(0,1).
    always_comb begin
        phase_cur  = {b_raw_reg, a_raw_reg ^ b_raw_reg};
        phase_next = i_reverse ? (phase_cur - 2'd1) : (phase_cur + 2'd1);
        a_raw_next = phase_next[1] ^ phase_next[0];
        b_raw_next = phase_next[1];
    end

    always_comb begin
        index_enabled = (i_steps_per_rev != '0);
        position_next = position_reg;
        if (!i_reverse) begin
            if (index_enabled && (position_reg >= i_steps_per_rev - K_POS_W'(1))) begin
                position_next = '0;
            end else begin
                position_next = position_reg + K_POS_W'(1);
            end
        end else begin
            if (index_enabled && ((position_reg == '0) || (position_reg >= i_steps_per_rev))) begin
                position_next = i_steps_per_rev - K_POS_W'(1);
            end else begin
                position_next = position_reg - K_POS_W'(1);
            end
        end
        index_next = index_enabled && (position_next == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg      <= '0;
            a_raw_reg      <= 1'b0;
            b_raw_reg      <= 1'b0;
            last_rev_reg   <= 1'b0;
            position_reg   <= '0;
            index_reg      <= 1'b0;
            step_reg       <= 1'b0;
            dir_change_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            step_reg       <= fire;
            dir_change_reg <= fire && (i_reverse != last_rev_reg);
            if (fire) begin
                a_raw_reg    <= a_raw_next;
                b_raw_reg    <= b_raw_next;
                last_rev_reg <= i_reverse;
                position_reg <= position_next;
                index_reg    <= index_next;
            end
        end
    end

    assign o_a          = i_polarity ? b_raw_reg : a_raw_reg;
    assign o_b          = i_polarity ? a_raw_reg : b_raw_reg;
    assign o_i          = index_reg;
    assign o_step       = step_reg;
    assign o_dir_change = dir_change_reg;
    assign o_position   = position_reg;

endmodule

// File: tb/tb_encoder_emulator.sv
// Bench for encoder_emulator: directed scenarios plus random stimulus against a step-level model.
module tb_encoder_emulator;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic [15:0] i_period;
    logic        i_reverse;
    logic        i_polarity;
    logic [9:0]  i_steps_per_rev;
    logic        i_single_step;
    logic        o_a, o_b, o_i, o_step, o_dir_change;
    logic [9:0]  o_position;

    int total = 0;
    int bad   = 0;

    // Reference state: elapsed cycles, quadrature phase, shaft position as plain integers.
    int m_elapsed, m_phase, m_pos, m_last_rev, m_idx, m_step, m_dc;
    int raw_a_tab[4] = '{0, 1, 1, 0};
    int raw_b_tab[4] = '{0, 0, 1, 1};

    encoder_emulator dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_period       (i_period),
        .i_reverse      (i_reverse),
        .i_polarity     (i_polarity),
        .i_steps_per_rev(i_steps_per_rev),
        .i_single_step  (i_single_step),
        .o_a            (o_a),
        .o_b            (o_b),
        .o_i            (o_i),
        .o_step         (o_step),
        .o_dir_change   (o_dir_change),
        .o_position     (o_position)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic model_reset();
        m_elapsed = 0; m_phase = 0; m_pos = 0; m_last_rev = 0;
        m_idx = 0; m_step = 0; m_dc = 0;
    endtask

    task automatic model_cycle();
        int per, s, rev, fire;
        per  = int'(i_period);
        s    = int'(i_steps_per_rev);
        rev  = int'(i_reverse);
        fire = 0;
        if (i_enable && per != 0 && m_elapsed >= per - 1) fire = 1;
        if (i_enable && per == 0 && i_single_step) fire = 1;
        if (i_enable) begin
            if (per == 0 || fire) m_elapsed = 0;
            else m_elapsed = m_elapsed + 1;
        end
        m_step = fire;
        m_dc   = 0;
        if (fire) begin
            m_dc       = (rev != m_last_rev) ? 1 : 0;
            m_last_rev = rev;
            m_phase    = rev ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
            if (!rev) begin
                if (s != 0 && m_pos >= s - 1) m_pos = 0;
                else m_pos = (m_pos + 1) % 1024;
            end else begin
                if (s != 0 && (m_pos == 0 || m_pos >= s)) m_pos = s - 1;
                else m_pos = (m_pos + 1023) % 1024;
            end
            m_idx = (m_pos == 0 && s != 0) ? 1 : 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [4:0] got_v, exp_v;
        logic [9:0] exp_pos;
        logic ra, rb;
        ra = raw_a_tab[m_phase][0];
        rb = raw_b_tab[m_phase][0];
        exp_v   = {i_polarity ? rb : ra, i_polarity ? ra : rb, m_idx[0], m_step[0], m_dc[0]};
        got_v   = {o_a, o_b, o_i, o_step, o_dir_change};
        exp_pos = m_pos[9:0];
        total++;
        assert (got_v === exp_v) else begin
            bad++;
            $error("FAIL %s a/b/i/step/dc got=%b expected=%b", tag, got_v, exp_v);
        end
        total++;
        assert (o_position === exp_pos) else begin
            bad++;
            $error("FAIL %s position got=%0d expected=%0d", tag, o_position, exp_pos);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp_val);
        total++;
        assert (got === exp_val) else begin
            bad++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp_val);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge i_clk);
        model_cycle();
        #1;
        check_outputs(tag);
    endtask

    task automatic reset_now();
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        int steps_seen;
        int hold_pos;
        i_rst_n = 1'b0; i_enable = 1'b0; i_period = 16'd0; i_reverse = 1'b0;
        i_polarity = 1'b0; i_steps_per_rev = 10'd8; i_single_step = 1'b0;
        model_reset();
        #12;
        check_outputs("reset_state");
        i_rst_n = 1'b1;

        // Forward run, period 4, eight steps per revolution
        i_period = 16'd4; i_enable = 1'b1;
        for (int k = 0; k < 40; k++) tick("fwd_p4");
        $display("forward run done: position=%0d", o_position);

        // Forward at period 3, then reverse through the 0 -> 7 wrap
        i_period = 16'd3;
        for (int k = 0; k < 12; k++) tick("fwd_p3");
        i_reverse = 1'b1;
        steps_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick("rev_p3");
            if (o_dir_change) steps_seen++;
        end
        check_val("dir_change_count", steps_seen, 1);
        i_reverse = 1'b0;

        // Single steps while stopped
        reset_now();
        i_period = 16'd0; i_enable = 1'b1;
        for (int n = 0; n < 3; n++) begin
            i_single_step = 1'b1;
            tick("single_step");
            i_single_step = 1'b0;
            tick("single_idle");
            tick("single_idle");
        end
        check_val("single_step_position", int'(o_position), 3);
        i_period = 16'd5;
        steps_seen = 0;
        for (int k = 0; k < 20; k++) begin
            i_single_step = k[0];
            tick("single_ignored");
            if (o_step) steps_seen++;
        end
        i_single_step = 1'b0;
        check_val("timed_steps_p5", steps_seen, 4);
        $display("single step phase done: position=%0d", o_position);

        // Lowered period mid-count fires next cycle
        i_period = 16'd0;
        tick("clear_count");
        i_period = 16'd100;
        for (int k = 0; k < 50; k++) tick("p100");
        i_period = 16'd10;
        tick("p100_to_10");
        check_val("lowered_period_step", int'(o_step), 1);
        i_period = 16'd1;
        steps_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick("p1");
            if (o_step) steps_seen++;
        end
        check_val("p1_every_cycle", steps_seen, 10);
        i_enable = 1'b0;
        hold_pos = int'(o_position);
        for (int k = 0; k < 10; k++) tick("frozen");
        check_val("frozen_position", int'(o_position), hold_pos);
        i_enable = 1'b1;
        i_period = 16'd7;
        for (int k = 0; k < 10; k++) tick("resume_p7");

        // Polarity swap, then index disabled with full 10-bit wrap
        i_polarity = 1'b1; i_period = 16'd2;
        for (int k = 0; k < 16; k++) tick("polarity");
        i_polarity = 1'b0; i_steps_per_rev = 10'd0; i_period = 16'd1;
        steps_seen = 0;
        for (int k = 0; k < 1100; k++) begin
            tick("s0_wrap");
            if (o_i) steps_seen++;
        end
        check_val("s0_no_index", steps_seen, 0);

        // Asynchronous reset mid-run at position 5
        i_steps_per_rev = 10'd8;
        reset_now();
        i_period = 16'd2;
        for (int k = 0; k < 40 && m_pos != 5; k++) tick("to_pos5");
        check_val("reached_pos5", int'(o_position), 5);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick("post_reset");
        tick("post_reset");
        check_val("post_reset_ab", int'({o_a, o_b}), 2);
        check_val("post_reset_pos", int'(o_position), 1);

        // Random stimulus
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) i_period = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) i_period = 16'($urandom_range(7, 40));
            i_enable      = ($urandom_range(0, 9) != 0);
            i_single_step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) i_reverse = ~i_reverse;
            if ($urandom_range(0, 29) == 0) i_polarity = ~i_polarity;
            if ($urandom_range(0, 199) == 0) i_steps_per_rev = 10'($urandom_range(0, 12));
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_emulator.md
Name: encoder_emulator

Overview:
Quadrature encoder emulator: generates A/B/I encoder signals from a commanded step period and direction. It is the transmitting end of the encoder interface that the motor control path reads.
- Outputs connect straight to the encoder inputs of the motor control top, for closed-loop bench tests and HIL/FPGA bring-up without a physical motor.
- Also exports the emulated shaft position and the step/direction-change events, so a checker can compare against the reader's decoded view.

Parameters:
K_PERIOD_W, 16, width of step-period command (clock cycles per quadrature step)
K_POS_W, 10, width of position counter and steps-per-revolution setting

Ports:
i_clk  in  1  master clock
i_rst_n  in  1  master reset, asynchronous, active-low
i_enable  in  1  1 = period counter runs; 0 = freeze (counter and outputs hold)
i_period  in  K_PERIOD_W  clock cycles per quadrature step; 0 = stopped
i_reverse  in  1  0 = forward (A leads B), 1 = reverse (B leads A)
i_polarity  in  1  1 = swap A and B on the outputs (matches reader polarity param)
i_steps_per_rev  in  K_POS_W  quadrature steps per revolution; 0 = index disabled, position wraps at 2^K_POS_W
i_single_step  in  1  one-cycle request for a single step; honoured only when i_period==0 and i_enable==1
o_a  out  1  encoder channel A
o_b  out  1  encoder channel B
o_i  out  1  encoder index
o_step  out  1  one-cycle pulse coincident with every A/B edge
o_dir_change  out  1  one-cycle pulse on the first step after a direction change
o_position  out  K_POS_W  emulated position in quadrature steps

Behaviour:
- Reset values:
  - o_a=0, o_b=0, o_i=0, o_step=0, o_dir_change=0, o_position=0.
  - Period counter = 0; stored last direction = forward; quadrature phase = 0.
- Quadrature phase (internal 2 bits), raw (A,B) per phase: 0=(0,0), 1=(1,0), 2=(1,1), 3=(0,1).
  - Forward step: phase+1 mod 4. Reverse step: phase-1 mod 4.
  - Exactly one of A/B toggles per step.
  - i_polarity=1 drives o_a=raw B, o_b=raw A. i_polarity is combinational on the registered raw pair, so it takes effect immediately.
- Period counter (K_PERIOD_W bits):
  - With i_enable=1 and i_period!=0: counts up each cycle.
  - When count >= i_period-1: a step fires and count returns to 0. The >= compare means a lowered period mid-run fires on the next cycle.
  - i_period==1: one step every cycle.
  - i_period==0 or i_enable=0: no timed steps. Count is held while i_enable=0 and cleared while i_period==0.
- Single step: i_single_step=1 with i_period==0 and i_enable==1 fires one step. Otherwise it is ignored and not queued.
- Step latency: all step effects are registered and appear on the clock edge that ends the cycle in which the step fires. A/B, o_i, o_position, o_step and o_dir_change all update on that same edge.
- Direction: i_reverse is sampled only when a step fires.
  - If it differs from the stored last direction: o_dir_change=1 for that cycle, and the stored direction is updated.
  - A change of i_reverse between steps has no effect until the next step.
- Position, with S = i_steps_per_rev:
  - Forward: if S!=0 and position >= S-1, next position = 0; else position+1 (mod 2^K_POS_W).
  - Reverse: if S!=0 and (position==0 or position >= S), next position = S-1; else position-1 (mod 2^K_POS_W).
- Index: o_i is registered and updated only on steps. It is 1 iff the new position==0 and S!=0, giving a one-step-wide index pulse.
- Reset mid-operation: all state returns to reset values asynchronously; the first step after reset is phase 0→1 (forward) or 0→3 (reverse).

Optional Feature:
ENCEMU_JITTER_EN
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances once per fired step.
  - When i_period >= 4, the terminal count becomes i_period-1 + lfsr[1:0], giving 0..3 cycles of jitter per step.
  - When i_period < 4, no jitter is applied.
  - The LFSR resets to the seed.
- When undefined: step period is exact; no LFSR logic.

Test Plan:
- Forward run: reset, i_period=4, i_enable=1, i_reverse=0, S=8 → o_step every 4 cycles; (o_a,o_b) = 10,11,01,00,...; o_position 1..7,0; o_i=1 only while position==0.
- Reverse with dir change: run forward at period 3, then set i_reverse=1 → the next step pulses o_dir_change for 1 cycle, phase sequence reverses, o_position decrements; wrap 0 → 7 with S=8.
- Stopped/single step: i_period=0, pulse i_single_step 3 times → exactly 3 steps, position=3. With i_period=5, i_single_step pulses → no extra steps.
- Period change/limits: running at i_period=100 with count=50, set i_period=10 → step on the next cycle. i_period=1 → step every cycle. i_enable=0 → outputs frozen, count held.
- Polarity and index disable: i_polarity=1 → o_a/o_b swapped versus the same run with polarity 0. S=0 → o_i stays 0 and position wraps 1023 → 0.
- Async reset mid-run at position 5: all outputs 0 immediately; the first step after release gives (o_a,o_b)=(1,0) and position=1.
